// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the FIFO UART drain path.
//   drain_state_t : encoding of the drain FSM states
//   UART_IDLE     : line level of an idle UART (mark)
//   clks_per_bit  : integer-truncated clock cycles per UART bit
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } drain_state_t;

    localparam logic UART_IDLE = 1'b1;

    // Truncating division keeps the bit period an exact number of clocks.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/fifo_uart_drain_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain_if
// Read port of the 16x8 synchronous FIFO as seen by its consumer.
//   fifo_empty      : FIFO empty flag (driven by the FIFO)
//   fifo_rd_data    : read data, valid the cycle after fifo_rd_request
//   fifo_rd_request : single-cycle pop strobe (driven by the consumer)
// Modports: master = consumer (drain), slave = FIFO.
// -----------------------------------------------------------------------------
interface fifo_uart_drain_if;

    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_request;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_request
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_request
    );

endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Restartable baud counter running 0..CLKS_PER_BIT-1. It only advances while
// run_i is high, so bit boundaries stay aligned to the start of each frame.
//   CLK100      in  system clock
//   reset       in  asynchronous active-high reset
//   restart_i   in  force the counter to 0 on the next edge (wins over run_i)
//   run_i       in  advance the counter
//   bit_done_o  out one-cycle pulse on the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic CLK100,
    input  logic reset,
    input  logic restart_i,
    input  logic run_i,
    output logic bit_done_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart, wrap at the end of a bit, or hold when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK100 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = run_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain
// Consumer end of the 16x8 FIFO: pops bytes and sends them as 8N1 UART frames,
// LSB first. All outputs come straight from flops.
//   CLK100      in  system clock
//   reset       in  asynchronous active-high reset
//   enable      in  drain enable (already synchronised)
//   fifo        --  FIFO read port (master side: empty/rd_data in, rd_request out)
//   txd         out UART serial output, idles high
//   busy        out high in every state except IDLE
//   sent_count  out frames completed since reset, modulo 256
// -----------------------------------------------------------------------------
module fifo_uart_drain
    import fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                     CLK100,
    input  logic                     reset,
    input  logic                     enable,
    fifo_uart_drain_if.master        fifo,
    output logic                     txd,
    output logic                     busy,
    output logic [7:0]               sent_count
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_FETCH = FETCH;
    localparam logic [2:0] ST_LATCH = LATCH;
    localparam logic [2:0] ST_START = START;
    localparam logic [2:0] ST_DATA  = DATA;
    localparam logic [2:0] ST_STOP  = STOP;

    logic [2:0] state_q,   state_d;
    logic       txd_q,     txd_d;
    logic       rd_req_q,  rd_req_d;
    logic       busy_q,    busy_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] sent_q,    sent_d;

    logic restart_s;
    logic run_s;
    logic bit_done_s;

    // Timer advances only while a frame is on the wire.
    assign run_s = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .CLK100     (CLK100),
        .reset      (reset),
        .restart_i  (restart_s),
        .run_i      (run_s),
        .bit_done_o (bit_done_s)
    );

    // Next-state logic. Outputs are computed one cycle ahead so they can be
    // registered; fifo_empty is only looked at in IDLE and on the last STOP cycle.
    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        rd_req_d  = 1'b0;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        sent_d    = sent_q;
        restart_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d = UART_IDLE;
                if (enable && !fifo.fifo_empty) begin
                    state_d  = ST_FETCH;
                    rd_req_d = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // Read data is valid now, one cycle after the pop strobe.
                shift_d   = fifo.fifo_rd_data;
                bit_idx_d = 3'd0;
                restart_s = 1'b1;
                txd_d     = 1'b0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (bit_done_s) begin
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = UART_IDLE;
                        state_d = ST_STOP;
                    end else begin
                        // shift_q[1] becomes the new LSB after this shift.
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                        state_d   = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    sent_d = sent_q + 8'd1;
                    if (enable && !fifo.fifo_empty) begin
                        state_d  = ST_FETCH;
                        rd_req_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                txd_d   = UART_IDLE;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge CLK100 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            txd_q     <= UART_IDLE;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            sent_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            rd_req_q  <= rd_req_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            sent_q    <= sent_d;
        end
    end

    assign fifo.fifo_rd_request = rd_req_q;
    assign txd                  = txd_q;
    assign busy                 = busy_q;
    assign sent_count           = sent_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_drain
// Directed bench for fifo_uart_drain at CLKS_PER_BIT = 10, with a 1-cycle
// latency FIFO model and a UART receiver monitor.
// -----------------------------------------------------------------------------
module tb_fifo_uart_drain;

    logic       CLK100 = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       txd;
    logic       busy;
    logic [7:0] sent_count;

    int checks = 0;
    int errors = 0;

    fifo_uart_drain_if bus ();

    fifo_uart_drain #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .CLK100     (CLK100),
        .reset      (reset),
        .enable     (enable),
        .fifo       (bus),
        .txd        (txd),
        .busy       (busy),
        .sent_count (sent_count)
    );

    always #5 CLK100 = ~CLK100;

    // Cycle counter used to time frame starts.
    int cyc = 0;
    always @(posedge CLK100) cyc <= cyc + 1;

    // FIFO model: 1-cycle read latency, pointers never wrap in this run.
    logic [7:0] fmem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_count = 0;
    int underflow_count = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge CLK100) begin
        if (bus.fifo_rd_request) begin
            pop_count <= pop_count + 1;
            if (wr_ptr != rd_ptr) begin
                bus.fifo_rd_data <= fmem[rd_ptr];
                rd_ptr <= rd_ptr + 1;
            end else begin
                underflow_count <= underflow_count + 1;
            end
        end
    end

    // UART receiver monitor: samples each bit near its middle.
    int         rx_count = 0;
    int         rx_ferr  = 0;
    logic [7:0] rx_bytes [0:1023];
    int         rx_start [0:1023];

    initial begin : rx_mon
        logic [7:0] b;
        forever begin
            @(negedge CLK100);
            if (!reset && txd === 1'b0) begin
                rx_start[rx_count] = cyc;
                repeat (4) @(negedge CLK100);
                if (txd !== 1'b0) rx_ferr++;
                for (int j = 0; j < 8; j++) begin
                    repeat (10) @(negedge CLK100);
                    b[j] = txd;
                end
                repeat (10) @(negedge CLK100);
                if (txd !== 1'b1) rx_ferr++;
                rx_bytes[rx_count] = b;
                rx_count++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK100);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin : stim
        int         rx_base;
        int         pop_base;
        int         ferr_base;
        logic [9:0] a5_bits;
        logic [7:0] exp_b;

        // ---- Reset state ----
        tick();
        tick();
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_rdreq", bus.fifo_rd_request, 0);
        check("rst_sent", sent_count, 0);
        reset = 1'b0;
        tick();
        check("idle_txd", txd, 1);

        // ---- Single byte 0xA5 ----
        rx_base  = rx_count;
        pop_base = pop_count;
        a5_bits  = 10'b1101001010;
        push(8'hA5);
        enable = 1'b1;
        tick();
        check("t2_rdreq_on", bus.fifo_rd_request, 1);
        check("t2_busy", busy, 1);
        tick();
        check("t2_rdreq_off", bus.fifo_rd_request, 0);
        check("t2_txd_fetch", txd, 1);
        tick();
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 10; c++) begin
                check($sformatf("t2_bit%0d_cyc%0d", j, c), txd, a5_bits[j]);
                tick();
            end
        end
        check("t2_sent", sent_count, 1);
        check("t2_busy_done", busy, 0);
        check("t2_pops", pop_count - pop_base, 1);
        check("t2_rx_count", rx_count - rx_base, 1);
        check("t2_rx_byte", rx_bytes[rx_base], 8'hA5);

        // ---- Back-to-back 0x01, 0x80, 0xFF ----
        rx_base   = rx_count;
        pop_base  = pop_count;
        ferr_base = rx_ferr;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        for (int i = 0; i < 600 && rx_count < rx_base + 3; i++) tick();
        for (int i = 0; i < 50 && busy !== 1'b0; i++) tick();
        check("t3_rx_count", rx_count - rx_base, 3);
        check("t3_byte0", rx_bytes[rx_base], 8'h01);
        check("t3_byte1", rx_bytes[rx_base + 1], 8'h80);
        check("t3_byte2", rx_bytes[rx_base + 2], 8'hFF);
        check("t3_gap01", rx_start[rx_base + 1] - rx_start[rx_base], 102);
        check("t3_gap12", rx_start[rx_base + 2] - rx_start[rx_base + 1], 102);
        check("t3_ferr", rx_ferr - ferr_base, 0);
        repeat (20) tick();
        check("t3_pops", pop_count - pop_base, 3);
        check("t3_empty", bus.fifo_empty, 1);
        check("t3_sent", sent_count, 4);
        check("t3_busy", busy, 0);

        // ---- Reset mid-frame ----
        pop_base = pop_count;
        push(8'h3C);
        repeat (40) tick();
        check("t1_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("t1_txd", txd, 1);
        check("t1_busy", busy, 0);
        check("t1_rdreq", bus.fifo_rd_request, 0);
        check("t1_sent", sent_count, 0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        repeat (110) tick();
        check("t1_lost_byte", bus.fifo_empty, 1);
        check("t1_pops", pop_count - pop_base, 1);
        check("t1_busy_after", busy, 0);
        check("t1_txd_after", txd, 1);

        // ---- Enable dropped during data bit 3 ----
        rx_base   = rx_count;
        pop_base  = pop_count;
        ferr_base = rx_ferr;
        push(8'h5A);
        push(8'hC3);
        enable = 1'b1;
        repeat (48) tick();
        check("t4_busy_mid", busy, 1);
        enable = 1'b0;
        for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
        check("t4_busy_end", busy, 0);
        repeat (200) tick();
        check("t4_rx_count", rx_count - rx_base, 1);
        check("t4_byte", rx_bytes[rx_base], 8'h5A);
        check("t4_ferr", rx_ferr - ferr_base, 0);
        check("t4_pops", pop_count - pop_base, 1);
        check("t4_left", wr_ptr - rd_ptr, 1);
        check("t4_sent", sent_count, 1);
        // Drain the byte left behind.
        enable = 1'b1;
        for (int i = 0; i < 300 && rx_count < rx_base + 2; i++) tick();
        for (int i = 0; i < 50 && busy !== 1'b0; i++) tick();
        check("t4_drain_count", rx_count - rx_base, 2);
        check("t4_drain_byte", rx_bytes[rx_base + 1], 8'hC3);
        check("t4_drain_sent", sent_count, 2);
        check("t4_drain_empty", bus.fifo_empty, 1);

        // ---- Underflow guard: enable high, FIFO empty ----
        pop_base = pop_count;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("t5_rdreq", bus.fifo_rd_request, 0);
            check("t5_txd", txd, 1);
            check("t5_busy", busy, 0);
        end
        check("t5_pops", pop_count - pop_base, 0);
        check("t5_underflow", underflow_count, 0);

        // ---- Wrap: 256 bytes 0x00..0xFF ----
        reset = 1'b1;
        tick();
        check("t6_sent_clr", sent_count, 0);
        reset = 1'b0;
        rx_base   = rx_count;
        pop_base  = pop_count;
        ferr_base = rx_ferr;
        for (int i = 0; i < 256; i++) push(8'(i));
        for (int i = 0; i < 27000 && rx_count < rx_base + 256; i++) tick();
        for (int i = 0; i < 50 && busy !== 1'b0; i++) tick();
        check("t6_rx_count", rx_count - rx_base, 256);
        for (int i = 0; i < 256; i++) begin
            exp_b = 8'(i);
            check($sformatf("t6_byte%0d", i), rx_bytes[rx_base + i], exp_b);
        end
        check("t6_ferr", rx_ferr - ferr_base, 0);
        check("t6_pops", pop_count - pop_base, 256);
        check("t6_sent_wrap", sent_count, 0);
        check("t6_empty", bus.fifo_empty, 1);
        check("t6_underflow", underflow_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
